// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq
//   Multi-cycle shifter between the ALU result and the bus driver. It accepts
//   an operand, an operation and a shift amount through a valid/ready handshake.
//   It then shifts the operand one bit position per clock and presents the
//   registered result through a second valid/ready handshake.
//
//   Operations (shift_operation):
//     000 pass, 001 SLL, 010 SRL, 011 ROL, 100 SRA, 101 ROR, 11x pass
//
//   Build option:
//     SHIFTER_CARRY_EN - adds out_carry, which holds the last bit shifted out.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   in_valid         operand/op/amount presented
//   in_ready         ready to accept (IDLE only)
//   from_alu         operand, WIDTH bits
//   shift_operation  operation code, 3 bits
//   shift_amount     positions to shift, 0..WIDTH-1
//   to_bus           registered result
//   out_valid        result valid (DONE only)
//   out_ready        consumer accepts the result
//   busy             high in SHIFT or DONE
//   out_carry        last bit shifted out (SHIFTER_CARRY_EN only)
// -----------------------------------------------------------------------------
module shifter_seq #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           from_alu,
    input  logic [2:0]                 shift_operation,
    input  logic [$clog2(WIDTH)-1:0]   shift_amount,
    output logic [WIDTH-1:0]           to_bus,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef SHIFTER_CARRY_EN
    output logic                       out_carry,
`endif
    output logic                       busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    // One single-bit step of the latched operation.
    function automatic logic [WIDTH-1:0] step_f(input logic [2:0] op,
                                                input logic [WIDTH-1:0] d);
        case (op)
            OP_SLL:  step_f = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  step_f = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  step_f = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  step_f = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  step_f = {d[0], d[WIDTH-1:1]};
            default: step_f = d;
        endcase
    endfunction

`ifdef SHIFTER_CARRY_EN
    // Bit leaving the word on one step: the MSB for left ops, the LSB for right ops.
    function automatic logic shifted_out_f(input logic [2:0] op,
                                           input logic [WIDTH-1:0] d);
        case (op)
            OP_SLL, OP_ROL:         shifted_out_f = d[WIDTH-1];
            OP_SRL, OP_SRA, OP_ROR: shifted_out_f = d[0];
            default:                shifted_out_f = 1'b0;
        endcase
    endfunction
`endif

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   data_q,   data_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]         op_q,     op_d;
    logic               is_pass_s;
`ifdef SHIFTER_CARRY_EN
    logic               carry_q,  carry_d;
`endif

    // Pass codes are 000 and 11x; they never enter SHIFT.
    assign is_pass_s = (shift_operation == OP_PASS) || (shift_operation[2:1] == 2'b11);

    // Next-state and datapath decode for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
`ifdef SHIFTER_CARRY_EN
        carry_d = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = from_alu;
                    op_d   = shift_operation;
                    cnt_d  = shift_amount;
`ifdef SHIFTER_CARRY_EN
                    carry_d = 1'b0;
`endif
                    if (is_pass_s || (shift_amount == CNT_ZERO)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = step_f(op_q, data_q);
                cnt_d  = cnt_q - CNT_ONE;
`ifdef SHIFTER_CARRY_EN
                carry_d = shifted_out_f(op_q, data_q);
`endif
                // cnt holds the steps still to do, including this one.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // The result stays put until the consumer takes it.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= CNT_ZERO;
            op_q    <= OP_PASS;
`ifdef SHIFTER_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`ifdef SHIFTER_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign to_bus    = data_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
`ifdef SHIFTER_CARRY_EN
    assign out_carry = carry_q;
`endif

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] from_alu;
    logic [2:0]   shift_operation;
    logic [2:0]   shift_amount;
    logic [W-1:0] to_bus;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         carry_obs;
`ifdef SHIFTER_CARRY_EN
    logic         out_carry;
`endif

    int checks = 0;
    int errors = 0;

    shifter_seq #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .from_alu        (from_alu),
        .shift_operation (shift_operation),
        .shift_amount    (shift_amount),
        .to_bus          (to_bus),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
`ifdef SHIFTER_CARRY_EN
        .out_carry       (out_carry),
`endif
        .busy            (busy)
    );

`ifdef SHIFTER_CARRY_EN
    assign carry_obs = out_carry;
`else
    assign carry_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pass(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd6) || (op == 3'd7);
    endfunction

    // Whole-amount reference using plain arithmetic on the operand.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic [2:0] op, input int n);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] t;
        dd = {d, d};
        case (op)
            3'd1: return W'(int'(d) << n);
            3'd2: return d >> n;
            3'd4: return W'($signed(d) >>> n);
            3'd3: begin t = dd << n; return t[2*W-1:W]; end
            3'd5: begin t = dd >> n; return t[W-1:0]; end
            default: return d;
        endcase
    endfunction

    // Last bit shifted out, 0 when nothing shifts.
    function automatic logic ref_carry(input logic [W-1:0] d, input logic [2:0] op, input int n);
        if (is_pass(op) || n == 0) return 1'b0;
`ifdef SHIFTER_CARRY_EN
        case (op)
            3'd1, 3'd3: return d[W-n];
            default:    return d[n-1];
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Waits (bounded) at falling edges until out_valid; returns the cycles waited.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    // One full transaction with optional backpressure in DONE.
    task automatic do_op(input logic [W-1:0] d, input logic [2:0] op, input int n, input int hold);
        int cyc;
        int lat;
        logic [W-1:0] exp;
        exp = ref_result(d, op, n);
        lat = (is_pass(op) || n == 0) ? 0 : n;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; from_alu = d; shift_operation = op; shift_amount = 3'(n);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        from_alu = W'($urandom); shift_operation = 3'($urandom); shift_amount = 3'($urandom);
        if (lat > 0) begin
            check("busy_in_shift", 32'(busy), 32'd1);
            check("in_ready_in_shift", 32'(in_ready), 32'd0);
        end
        wait_valid(cyc);
        check("latency", 32'(cyc), 32'(lat));
        check("result", 32'(to_bus), 32'(exp));
        check("carry", 32'(carry_obs), 32'(ref_carry(d, op, n)));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_to_bus", 32'(to_bus), 32'(exp));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] rd;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        from_alu = '0; shift_operation = 3'd0; shift_amount = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_to_bus", 32'(to_bus), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_carry", 32'(carry_obs), 32'd0);

        // Directed cases.
        do_op(8'h81, 3'd1, 1, 0);
        do_op(8'h81, 3'd3, 3, 0);
        do_op(8'h01, 3'd5, 1, 0);
        do_op(8'h80, 3'd4, 7, 0);
        do_op(8'h80, 3'd2, 7, 0);
        do_op(8'h80, 3'd7, 5, 0);
        do_op(8'h5A, 3'd6, 0, 0);
        do_op(8'hC3, 3'd1, 7, 5);
        do_op(8'h3C, 3'd5, 0, 1);

        // Reset while shifting with 4 steps still to go.
        in_valid = 1'b1; from_alu = 8'hFF; shift_operation = 3'd1; shift_amount = 3'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_to_bus", 32'(to_bus), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; from_alu = 8'h96; shift_operation = 3'd3; shift_amount = 3'd2;
        @(posedge clk);
        @(negedge clk);
        from_alu = 8'h69; shift_operation = 3'd2; shift_amount = 3'd3;
        out_ready = 1'b1;
        wait_valid(cyc);
        check("b2b_first", 32'(to_bus), 32'(ref_result(8'h96, 3'd3, 2)));
        @(posedge clk);
        @(negedge clk);
        check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        check("b2b_gap_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accepted", 32'(in_ready), 32'd0);
        wait_valid(cyc);
        check("b2b_second_latency", 32'(cyc), 32'd3);
        check("b2b_second", 32'(to_bus), 32'(ref_result(8'h69, 3'd2, 3)));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_end_in_ready", 32'(in_ready), 32'd1);

        // Randomised transactions.
        for (int i = 0; i < 40; i++) begin
            rd = W'($urandom);
            do_op(rd, 3'($urandom_range(0, 7)), int'($urandom_range(0, W - 1)),
                  int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
